// File: rtl/acc_sum_unit_pkg.sv
// Shared definitions for the burst accumulator.
// Contents: FSM state encoding and default datapath widths.
package acc_sum_unit_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/acc_sum_unit_if.sv
// Operand stream between the operand source and the accumulator.
// Signals: in_valid (source -> unit), in_data (source -> unit),
//          in_ready (unit -> source).
// Modports: master = operand source, slave = accumulator.
interface acc_sum_unit_if #(
  parameter int WIDTH = 32
);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );

endinterface

// File: rtl/acc_sum_unit_rca_add.sv
// rca_add: WIDTH-bit combinational ripple-carry adder.
// Ports: a, b (operands), sum (a+b mod 2^WIDTH), cout (carry out of MSB).
module rca_add #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry_s;

  assign carry_s[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign sum[i]       = a[i] ^ b[i] ^ carry_s[i];
    assign carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
  end

  assign cout = carry_s[WIDTH];

endmodule

// File: rtl/acc_sum_unit.sv
// acc_sum_unit: accumulates a burst of len operands received over a
// valid/ready stream into a running sum.
// Ports:
//   clk      - rising-edge clock
//   rst_n    - synchronous active-low reset
//   start    - begin a burst (sampled only when idle)
//   len      - operands in the burst, latched with start
//   in_if    - operand stream (slave side: in_valid, in_data, in_ready)
//   busy     - burst in progress
//   acc_out  - accumulator; holds after done until the next start
//   ovf      - sticky carry-out over the current burst
//   done     - one-cycle pulse when the burst is complete
//   count    - operands accepted in the current burst
module acc_sum_unit
  import acc_sum_unit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  acc_sum_unit_if.slave    in_if,
  output logic             busy,
  output logic [WIDTH-1:0] acc_out,
  output logic             ovf,
  output logic             done,
  output logic [CNT_W-1:0] count
);

  state_t           state_r, next_state_s;
  logic [WIDTH-1:0] acc_r, acc_nxt_s;
  logic             ovf_r, ovf_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s, cnt_inc_s;
  logic [CNT_W-1:0] len_r, len_nxt_s;
  logic             in_ready_r, done_r, busy_r;
  logic             hs_s;
  logic [WIDTH-1:0] sum_s;
  logic             cout_s;

  rca_add #(.WIDTH(WIDTH)) u_add (
    .a    (acc_r),
    .b    (in_if.in_data),
    .sum  (sum_s),
    .cout (cout_s)
  );

  // in_ready_r is high exactly while in ACCUM, so this is the handshake.
  assign hs_s      = in_if.in_valid & in_ready_r;
  assign cnt_inc_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};

  // Next-state and datapath update decode.
  always_comb begin
    next_state_s = state_r;
    acc_nxt_s    = acc_r;
    ovf_nxt_s    = ovf_r;
    cnt_nxt_s    = cnt_r;
    len_nxt_s    = len_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          acc_nxt_s = {WIDTH{1'b0}};
          ovf_nxt_s = 1'b0;
          cnt_nxt_s = {CNT_W{1'b0}};
          len_nxt_s = len;
          if (len == {CNT_W{1'b0}}) begin
            next_state_s = ST_DONE;
          end else begin
            next_state_s = ST_ACCUM;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (hs_s) begin
          acc_nxt_s = sum_s;
          ovf_nxt_s = ovf_r | cout_s;
          cnt_nxt_s = cnt_inc_s;
          if (cnt_inc_s == len_r) begin
            next_state_s = ST_DONE;
          end else begin
            next_state_s = ST_ACCUM;
          end
        end else begin
          next_state_s = ST_ACCUM;
        end
      end
      ST_DONE: begin
        next_state_s = ST_IDLE;
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and output registers; outputs are registered copies of
  // the next-state decode so they track the state exactly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      acc_r      <= {WIDTH{1'b0}};
      ovf_r      <= 1'b0;
      cnt_r      <= {CNT_W{1'b0}};
      len_r      <= {CNT_W{1'b0}};
      in_ready_r <= 1'b0;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      acc_r      <= acc_nxt_s;
      ovf_r      <= ovf_nxt_s;
      cnt_r      <= cnt_nxt_s;
      len_r      <= len_nxt_s;
      in_ready_r <= (next_state_s == ST_ACCUM);
      done_r     <= (next_state_s == ST_DONE);
      busy_r     <= (next_state_s != ST_IDLE);
    end
  end

  assign in_if.in_ready = in_ready_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign acc_out        = acc_r;
  assign ovf            = ovf_r;
  assign count          = cnt_r;

endmodule

// File: tb/tb_acc_sum_unit.sv
// Self-checking bench for acc_sum_unit: directed bursts with literal
// expectations plus randomized traffic, all compared every cycle against a
// transaction-level model of the accumulator.
module tb_acc_sum_unit;

  localparam int WIDTH = 32;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] len;
  logic             busy;
  logic [WIDTH-1:0] acc_out;
  logic             ovf;
  logic             done;
  logic [CNT_W-1:0] count;

  acc_sum_unit_if #(.WIDTH(WIDTH)) bus ();

  acc_sum_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .len     (len),
    .in_if   (bus),
    .busy    (busy),
    .acc_out (acc_out),
    .ovf     (ovf),
    .done    (done),
    .count   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a burst is "len operands remaining"; the sum is
  // plain 64-bit arithmetic folded mod 2^32, overflow is any sum >= 2^32.
  bit          m_known = 1'b0;
  bit          m_taking = 1'b0;
  bit          m_done = 1'b0;
  int          m_left = 0;
  int          m_cnt = 0;
  longint      m_acc = 0;
  bit          m_ovf = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_known = 1'b1; m_taking = 1'b0; m_done = 1'b0;
      m_left = 0; m_cnt = 0; m_acc = 0; m_ovf = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_taking) begin
      if (bus.in_valid) begin
        longint s;
        s = m_acc + longint'(bus.in_data);
        if (s >= 64'h1_0000_0000) m_ovf = 1'b1;
        m_acc = s % 64'h1_0000_0000;
        m_cnt++;
        m_left--;
        if (m_left == 0) begin
          m_taking = 1'b0;
          m_done = 1'b1;
        end
      end
    end else if (start) begin
      m_acc = 0; m_ovf = 1'b0; m_cnt = 0;
      m_left = int'(len);
      if (m_left == 0) m_done = 1'b1;
      else m_taking = 1'b1;
    end
  end

  // Every-cycle comparison against the model, just after the active edge.
  always @(posedge clk) begin
    #1;
    if (m_known) begin
      chk("acc_out",  longint'(acc_out),      m_acc);
      chk("ovf",      longint'(ovf),          longint'(m_ovf));
      chk("count",    longint'(count),        longint'(m_cnt));
      chk("done",     longint'(done),         longint'(m_done));
      chk("in_ready", longint'(bus.in_ready), longint'(m_taking));
      chk("busy",     longint'(busy),         longint'(m_taking | m_done));
    end
  end

  task automatic idle_inputs();
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = $urandom;
  endtask

  task automatic do_reset(input int edges);
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    repeat (edges) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Start pulse is held for exactly one edge.
  task automatic start_burst(input int l);
    @(negedge clk);
    start = 1'b1;
    len = CNT_W'(l);
    @(negedge clk);
    start = 1'b0;
    len = CNT_W'($urandom);
  endtask

  // Present one operand until it is accepted (checked on negedge before the
  // accepting edge); a stuck in_ready counts as a failure.
  task automatic send(input logic [WIDTH-1:0] d, input bit poke_start);
    int waited;
    waited = 0;
    bus.in_valid = 1'b1;
    bus.in_data = d;
    start = poke_start;
    while (bus.in_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("send_accept_timeout", longint'(waited < 20), 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data = $urandom;
    start = 1'b0;
  endtask

  task automatic gap(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      bus.in_data = $urandom;
      @(negedge clk);
    end
  endtask

  // Called right after the last send: done must be high now and gone next cycle.
  task automatic expect_end(input string tag, input longint exp_acc, input bit exp_ovf,
                            input int exp_cnt);
    chk({tag, "_done"}, longint'(done), 1);
    chk({tag, "_acc"},  longint'(acc_out), exp_acc);
    chk({tag, "_ovf"},  longint'(ovf), longint'(exp_ovf));
    chk({tag, "_cnt"},  longint'(count), longint'(exp_cnt));
    @(negedge clk);
    chk({tag, "_done_single"}, longint'(done), 0);
    chk({tag, "_idle"}, longint'(busy), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    len = '0;
    idle_inputs();

    // 1 Reset
    repeat (2) @(negedge clk);
    chk("rst_acc", longint'(acc_out), 0);
    chk("rst_ovf", longint'(ovf), 0);
    chk("rst_cnt", longint'(count), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_ready", longint'(bus.in_ready), 0);
    chk("rst_busy", longint'(busy), 0);
    rst_n = 1'b1;

    // 2 Basic back-to-back
    start_burst(2);
    send(32'd454, 1'b0);
    chk("basic_mid_cnt", longint'(count), 1);
    bus.in_valid = 1'b1; bus.in_data = 32'd69;
    @(negedge clk);
    bus.in_valid = 1'b0;
    expect_end("basic", 523, 1'b0, 2);

    // 3 Stalls between operands
    start_burst(3);
    send(32'd1, 1'b0); gap(2);
    chk("stall_cnt1", longint'(count), 1);
    send(32'd2, 1'b0); gap(2);
    chk("stall_cnt2", longint'(count), 2);
    send(32'd3, 1'b0);
    expect_end("stall", 6, 1'b0, 3);

    // 4 Overflow, then ovf cleared by next burst
    start_burst(2);
    send(32'hFFFF_FFFF, 1'b0);
    send(32'h0000_0002, 1'b0);
    expect_end("ovf", 1, 1'b1, 2);
    start_burst(1);
    send(32'd5, 1'b0);
    expect_end("ovf_clr", 5, 1'b0, 1);

    // 5 Empty burst; start pulsed during ACCUM is ignored
    @(negedge clk);
    start = 1'b1; len = '0;
    @(negedge clk);
    start = 1'b0;
    chk("empty_ready", longint'(bus.in_ready), 0);
    expect_end("empty", 0, 1'b0, 0);
    start_burst(2);
    send(32'd10, 1'b1);
    send(32'd20, 1'b0);
    expect_end("ign_start", 30, 1'b0, 2);

    // 6 Reset mid-burst
    start_burst(4);
    send(32'd100, 1'b0);
    send(32'd200, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_acc", longint'(acc_out), 0);
    chk("mid_rst_cnt", longint'(count), 0);
    chk("mid_rst_busy", longint'(busy), 0);
    chk("mid_rst_done", longint'(done), 0);
    start_burst(1);
    send(32'd7, 1'b0);
    expect_end("after_rst", 7, 1'b0, 1);

    // Randomized traffic, checked by the per-cycle model comparison
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 299) != 0);
      start = ($urandom_range(0, 5) == 0);
      len = CNT_W'($urandom_range(0, 6));
      bus.in_valid = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) == 0) bus.in_data = 32'hFFFF_0000 | 32'($urandom_range(0, 65535));
      else bus.in_data = $urandom;
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
